// File: rtl/axi_pkg.sv
// Shared AXI4 constants, read-initiator state type and a size-encode helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam int         AXI_4K_BOUNDARY = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } rd_state_t;

  // AXI arsize encoding: log2 of the bytes per beat.
  function automatic logic [2:0] axi_size_enc(input int unsigned bytes);
    logic [2:0] sz;
    sz = '0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry registered valid/ready buffer; full is exported so the producer can throttle.
module skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk_tb,
  input  logic             i_RST_N,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic             empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk_tb) begin
    if (i_RST_N) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits one (address, beats) request into INCR bursts and streams the data.
// i_RST_N is a synchronous active-high reset. Define AXI_RD_4K_SPLIT_EN to keep bursts inside 4 KiB.
module axi_burst_reader
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk_tb,
  input  logic                  i_RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  err
);

  // state | meaning
  // IDLE  | waiting for a request, output buffer drained
  // ADDR  | AR presented, araddr/arlen held until arready
  // DATA  | collecting the counted beats of the current burst
  localparam int STRB_SHIFT = $clog2(STRB_WIDTH);
  localparam int REM_W      = LEN_WIDTH + 1;

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, load_addr;
  logic [REM_W-1:0]      rem_q, load_rem;
  logic [8:0]            beats_q, beats_nxt, beat_cnt_q;
  logic [31:0]           cand;
  logic                  load, ar_hs, r_hs, last_beat, req_last;
  logic                  buf_full, buf_empty, buf_valid;
  logic [DATA_WIDTH:0]   buf_dout;

  assign arsize    = axi_size_enc(STRB_WIDTH);
  assign arburst   = AXI_BURST_INCR;
  assign out_valid = buf_valid;
  assign out_data  = buf_dout[DATA_WIDTH-1:0];
  assign out_last  = buf_dout[DATA_WIDTH] && buf_valid;

  always_comb begin
    req_ready = (state_q == ST_IDLE) && buf_empty && !i_RST_N;
    rready    = (state_q == ST_DATA) && !buf_full && !i_RST_N;
    ar_hs     = arvalid && arready;
    r_hs      = rvalid && rready;
    last_beat = (beat_cnt_q == 9'd1);
    req_last  = last_beat && (rem_q == REM_W'(beats_q));
    state_d   = state_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid && req_ready) begin
        state_d = ST_ADDR;
        load    = 1'b1;
      end
      ST_ADDR: if (ar_hs) state_d = ST_DATA;
      ST_DATA: if (r_hs && last_beat) begin
        if (req_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ADDR;
          load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next burst parameters, either from a fresh request or advancing past the burst just finished.
  always_comb begin
    if (state_q == ST_IDLE) begin
      load_addr = req_addr;
      load_rem  = REM_W'(req_len) + REM_W'(1);
    end else begin
      load_addr = addr_q + (ADDR_WIDTH'(beats_q) << STRB_SHIFT);
      load_rem  = rem_q - REM_W'(beats_q);
    end
    cand = 32'(load_rem);
    if (cand > 32'(MAX_BURST)) cand = 32'(MAX_BURST);
`ifdef AXI_RD_4K_SPLIT_EN
    if (cand > ((32'(AXI_4K_BOUNDARY) - (32'(load_addr) & 32'hFFF)) >> STRB_SHIFT))
      cand = (32'(AXI_4K_BOUNDARY) - (32'(load_addr) & 32'hFFF)) >> STRB_SHIFT;
`endif
    beats_nxt = 9'(cand);
  end

  always_ff @(posedge clk_tb) begin
    if (i_RST_N) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      araddr     <= '0;
      arlen      <= '0;
      arvalid    <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= out_valid && out_ready && out_last;
      if (load) begin
        addr_q  <= load_addr;
        rem_q   <= load_rem;
        beats_q <= beats_nxt;
        araddr  <= load_addr;
        arlen   <= 8'(beats_nxt - 9'd1);
        arvalid <= 1'b1;
      end else if (ar_hs) begin
        arvalid <= 1'b0;
      end
      if (ar_hs) beat_cnt_q <= beats_q;
      else if (r_hs) beat_cnt_q <= beat_cnt_q - 9'd1;
      // The beat counter, not rlast, decides where a burst ends; a disagreeing rlast only flags err.
      if ((state_q == ST_IDLE) && load) err <= 1'b0;
      else if (r_hs && ((rresp != AXI_RESP_OKAY) || (rlast != last_beat))) err <= 1'b1;
    end
  end

  skid_buf #(.WIDTH(DATA_WIDTH + 1)) u_skid_buf (
    .clk_tb    (clk_tb),
    .i_RST_N   (i_RST_N),
    .in_valid  (r_hs),
    .in_data   ({req_last, rdata}),
    .full      (buf_full),
    .empty     (buf_empty),
    .out_valid (buf_valid),
    .out_ready (out_ready),
    .out_data  (buf_dout)
  );

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: RAM responder, burst/stream reference model, directed + random requests.
module tb_axi_burst_reader;

  localparam int DW   = 8;
  localparam int AW   = 15;
  localparam int STRB = 1;
  localparam int MAXB = 16;
  localparam int LW   = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    l;
  } ar_t;

  logic          clk_tb = 1'b0;
  logic          i_RST_N = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          done;
  logic          err;

  always #5 clk_tb = ~clk_tb;

  axi_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(STRB), .MAX_BURST(MAXB), .LEN_WIDTH(LW)
  ) dut (
    .clk_tb(clk_tb), .i_RST_N(i_RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err)
  );

  int n_pass = 0, n_fail = 0, n_total = 0;

  ar_t           exp_ar[$];
  logic [DW:0]   exp_data[$];
  ar_t           ar_q[$];
  int            ar_mode = 0, rv_mode = 0, or_mode = 0;
  int            inj_resp_at = -1, inj_rlast_at = -1;
  logic          inj_rlast_on = 1'b0;
  int            r_total = 0;

  // Values seen at the falling edge, i.e. what the next rising edge will act on.
  logic          rst_e = 1'b1, ar_fire_e = 1'b0, r_fire_e = 1'b0;
  ar_t           cap_ar;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_byte(input int a);
    return DW'(a ^ (a >> 5) ^ 32'h5A);
  endfunction

  // Reference: burst list and beat stream derived straight from the splitting rules.
  task automatic model_req(input int addr, input int len);
    int  a, rem, b;
    ar_t t;
    a   = addr;
    rem = len + 1;
    while (rem > 0) begin
      b = (rem < MAXB) ? rem : MAXB;
`ifdef AXI_RD_4K_SPLIT_EN
      if (b > (4096 - (a % 4096)) / STRB) b = (4096 - (a % 4096)) / STRB;
`endif
      t.a = AW'(a);
      t.l = 8'(b - 1);
      exp_ar.push_back(t);
      a   += b * STRB;
      rem -= b;
    end
    for (int i = 0; i <= len; i++) exp_data.push_back({(i == len), mem_byte(addr + i * STRB)});
  endtask

  // Monitor and checker.
  int   occ = 0;
  logic done_exp = 1'b0, ar_hold = 1'b0;
  ar_t  hold_ar;
  always @(negedge clk_tb) begin
    logic        o_fire;
    ar_t         e;
    logic [DW:0] d;
    rst_e     = i_RST_N;
    ar_fire_e = arvalid && arready;
    r_fire_e  = rvalid && rready;
    o_fire    = out_valid && out_ready;
    cap_ar.a  = araddr;
    cap_ar.l  = arlen;
    if (i_RST_N) begin
      occ      = 0;
      done_exp = 1'b0;
      ar_hold  = 1'b0;
    end else begin
      if (ar_hold) begin
        check("ar_hold_valid", 32'(arvalid), 32'(1));
        check("ar_hold_addr", 32'(araddr), 32'(hold_ar.a));
        check("ar_hold_len", 32'(arlen), 32'(hold_ar.l));
      end
      if (ar_fire_e) begin
        check("ar_one_outstanding", 32'(ar_q.size()), 32'(0));
        check("arsize", 32'(arsize), 32'($clog2(STRB)));
        check("arburst", 32'(arburst), 32'(1));
        if (exp_ar.size() == 0) check("ar_unexpected", 32'(1), 32'(0));
        else begin
          e = exp_ar.pop_front();
          check("araddr", 32'(araddr), 32'(e.a));
          check("arlen", 32'(arlen), 32'(e.l));
        end
      end
      check("out_valid_timing", 32'(out_valid), 32'(occ != 0));
      if (occ == 2) check("rready_full", 32'(rready), 32'(0));
      check("done_pulse", 32'(done), 32'(done_exp));
      if (o_fire) begin
        if (exp_data.size() == 0) check("beat_extra", 32'(1), 32'(0));
        else begin
          d = exp_data.pop_front();
          check("out_data", 32'(out_data), 32'(d[DW-1:0]));
          check("out_last", 32'(out_last), 32'(d[DW]));
        end
      end
      done_exp = o_fire && out_last;
      occ      = occ + int'(r_fire_e) - int'(o_fire);
      ar_hold  = arvalid && !arready;
      hold_ar  = cap_ar;
    end
  end

  // RAM-side responder and stream sink.
  int beat = 0, ar_wait = 0;
  always @(posedge clk_tb) begin
    int  a;
    ar_t tmp;
    #1;
    if (rst_e) begin
      ar_q.delete();
      beat = 0; ar_wait = 0;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0; out_ready = 1'b0;
    end else begin
      if (ar_fire_e) ar_q.push_back(cap_ar);
      if (r_fire_e && ar_q.size() > 0) begin
        r_total++;
        if (beat == int'(ar_q[0].l)) begin
          tmp  = ar_q.pop_front();
          beat = 0;
        end else beat++;
      end
      ar_wait = arvalid ? ar_wait + 1 : 0;
      case (ar_mode)
        0:       arready = 1'b1;
        1:       arready = (ar_wait >= 3);
        default: arready = 1'($urandom_range(0, 1));
      endcase
      if (!(rvalid && !r_fire_e)) begin
        if (ar_q.size() > 0) rvalid = (rv_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        else rvalid = 1'b0;
      end
      if (ar_q.size() > 0) begin
        a     = int'(ar_q[0].a) + beat * STRB;
        rdata = mem_byte(a);
        rlast = inj_rlast_on ? (r_total == inj_rlast_at) : (beat == int'(ar_q[0].l));
        rresp = (r_total == inj_resp_at) ? 2'b10 : 2'b00;
      end else begin
        rlast = 1'b0;
        rresp = 2'b00;
      end
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic reset_checks();
    check("rst_arvalid", 32'(arvalid), 32'(0));
    check("rst_rready", 32'(rready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_araddr", 32'(araddr), 32'(0));
    check("rst_arlen", 32'(arlen), 32'(0));
  endtask

  task automatic accept_req(input int addr, input int len);
    int cyc;
    model_req(addr, len);
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    req_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk_tb);
      cyc++;
    end while (!req_ready && cyc < 200);
    check("req_accept_timeout", 32'(req_ready), 32'(1));
    @(posedge clk_tb);
    #1 req_valid = 1'b0;
    @(negedge clk_tb);
    check("arvalid_after_req", 32'(arvalid), 32'(1));
    check("err_cleared", 32'(err), 32'(0));
  endtask

  task automatic do_req(input int addr, input int len, input logic err_exp);
    int cyc;
    accept_req(addr, len);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk_tb);
      cyc++;
    end
    check("done_timeout", 32'(done), 32'(1));
    check("req_ready_with_done", 32'(req_ready), 32'(1));
    check("beats_left", 32'(exp_data.size()), 32'(0));
    check("bursts_left", 32'(exp_ar.size()), 32'(0));
    check("err_final", 32'(err), 32'(err_exp));
    @(posedge clk_tb);
    #1;
  endtask

  initial begin
    i_RST_N = 1'b1;
    repeat (3) @(posedge clk_tb);
    #1;
    reset_checks();
    i_RST_N = 1'b0;
    @(negedge clk_tb);
    check("req_ready_after_rst", 32'(req_ready), 32'(1));
    @(posedge clk_tb);
    #1;

    do_req(0, 15, 1'b0);
    do_req(32'h040, 39, 1'b0);
    do_req(32'h0FF8, 15, 1'b0);

    ar_mode = 1; or_mode = 1; rv_mode = 1;
    do_req(32'h100, 20, 1'b0);
    ar_mode = 0; or_mode = 0; rv_mode = 0;

    inj_resp_at = r_total + 2;
    do_req(32'h200, 7, 1'b1);
    inj_resp_at = -1;

    inj_rlast_on = 1'b1;
    inj_rlast_at = r_total + 4;
    do_req(32'h300, 7, 1'b1);
    inj_rlast_on = 1'b0;
    inj_rlast_at = -1;

    do_req(32'h400, 3, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ar_mode = int'($urandom_range(0, 2));
      rv_mode = int'($urandom_range(0, 1));
      or_mode = int'($urandom_range(0, 2));
      do_req(int'($urandom_range(0, 28000)), int'($urandom_range(0, 60)), 1'b0);
    end

    ar_mode = 0; rv_mode = 0; or_mode = 1;
    accept_req(32'h500, 39);
    repeat (12) @(posedge clk_tb);
    #1 i_RST_N = 1'b1;
    @(posedge clk_tb);
    #1;
    reset_checks();
    exp_ar.delete();
    exp_data.delete();
    i_RST_N = 1'b0;
    @(negedge clk_tb);
    check("req_ready_after_mid_rst", 32'(req_ready), 32'(1));
    @(posedge clk_tb);
    #1;
    or_mode = 0;
    do_req(32'h600, 9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
